// File: rtl/uart_tx_engine.sv
// UART transmit engine with an integrated TX FIFO, paced by an external OSR-per-bit baud tick.
// Optional CTS flow control (cts_n port plus 2-flop synchroniser) is enabled by `define UART_TX_CTS_EN.
module uart_tx_engine #(
    parameter  int FIFO_DEPTH = 16,
    parameter  int OSR        = 16,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [7:0]    lcr,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          tx_reset,
    input  logic          ovr_clr,
`ifdef UART_TX_CTS_EN
    input  logic          cts_n,
`endif
    output logic          stx_pad_o,
    output logic [2:0]    tstate,
    output logic [CW-1:0] tf_count,
    output logic          tf_full,
    output logic          tf_empty,
    output logic          tf_overrun,
    output logic          tx_idle
);
    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0] OSR_M1    = 8'(OSR - 1);
    localparam logic [7:0] STOP15_M1 = 8'((3 * OSR) / 2 - 1);
    localparam logic [7:0] STOP2_M1  = 8'(2 * OSR - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_POP    = 3'd5
    } state_t;

    function automatic logic [7:0] char_mask(input logic [1:0] len);
        case (len)
            2'b00:   char_mask = 8'h1F;
            2'b01:   char_mask = 8'h3F;
            2'b10:   char_mask = 8'h7F;
            default: char_mask = 8'hFF;
        endcase
    endfunction

    function automatic logic parity_bit(input logic xor_bit, input logic ep, input logic sp);
        case ({ep, sp})
            2'b00:   parity_bit = ~xor_bit;
            2'b01:   parity_bit = 1'b1;
            2'b10:   parity_bit = xor_bit;
            default: parity_bit = 1'b0;
        endcase
    endfunction

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_next_s;
    logic          full_r, empty_r, overrun_r, tx_idle_r;
    logic          push_s, pop_s, ovr_set_s, cts_ok_s;
    logic [7:0]    head_s, head_masked_s;
    state_t        state_r, state_next_s;
    logic [7:0]    tick_r, tick_next_s, stop_last_s;
    logic [2:0]    bit_r, bit_next_s, last_bit_s;
    logic [7:0]    data_r;
    logic [5:0]    lcr_r;
    logic          parity_r, line_r, line_next_s;
    logic          lcr_unused_s;

    assign lcr_unused_s = lcr[7];

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_r;
    // Two-flop synchroniser for the asynchronous clear-to-send input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cts_sync_r <= 2'b11;
        else     cts_sync_r <= {cts_sync_r[0], cts_n};
    end
    assign cts_ok_s = ~cts_sync_r[1];
`else
    assign cts_ok_s = 1'b1;
`endif

    assign head_s        = mem_r[rd_ptr_r];
    assign head_masked_s = head_s & char_mask(lcr[1:0]);
    assign push_s        = wr_en & (~full_r | pop_s);
    assign ovr_set_s     = wr_en & full_r & ~pop_s;

    // Pop only on the POP tick and only if a flush has not emptied the FIFO meanwhile.
    always_comb begin
        if (enable && (state_r == ST_POP) && !empty_r) pop_s = 1'b1;
        else                                           pop_s = 1'b0;
    end

    // Next FIFO occupancy; a flush overrides any push or pop in the same clock.
    always_comb begin
        if (tx_reset)             count_next_s = {CW{1'b0}};
        else if (push_s && !pop_s) count_next_s = count_r + CW'(1);
        else if (!push_s && pop_s) count_next_s = count_r - CW'(1);
        else                      count_next_s = count_r;
    end

    // FIFO storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s && !tx_reset) mem_r[wr_ptr_r] <= wr_data;
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            overrun_r <= 1'b0;
            tx_idle_r <= 1'b1;
        end else begin
            count_r   <= count_next_s;
            full_r    <= (count_next_s == CW'(FIFO_DEPTH));
            empty_r   <= (count_next_s == {CW{1'b0}});
            tx_idle_r <= (count_next_s == {CW{1'b0}}) && (state_next_s == ST_IDLE);
            if (tx_reset) begin
                wr_ptr_r  <= {AW{1'b0}};
                rd_ptr_r  <= {AW{1'b0}};
                overrun_r <= 1'b0;
            end else begin
                if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
                if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
                if (ovr_set_s)    overrun_r <= 1'b1;
                else if (ovr_clr) overrun_r <= 1'b0;
            end
        end
    end

    // Frame geometry from the settings latched at POP.
    always_comb begin
        last_bit_s = 3'd4 + {1'b0, lcr_r[1:0]};
        if (!lcr_r[2])                stop_last_s = OSR_M1;
        else if (lcr_r[1:0] == 2'b00) stop_last_s = STOP15_M1;
        else                          stop_last_s = STOP2_M1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_next_s;
    end

    // FSM next-state and tick/bit counter update; everything moves only on a baud tick.
    always_comb begin
        state_next_s = state_r;
        tick_next_s  = tick_r;
        bit_next_s   = bit_r;
        if (enable) begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_r && cts_ok_s) state_next_s = ST_POP;
                    else                      state_next_s = ST_IDLE;
                end
                ST_POP: begin
                    tick_next_s = 8'd0;
                    if (!empty_r) state_next_s = ST_START;
                    else          state_next_s = ST_IDLE;
                end
                ST_START: begin
                    if (tick_r == OSR_M1) begin
                        state_next_s = ST_DATA;
                        tick_next_s  = 8'd0;
                        bit_next_s   = 3'd0;
                    end else begin
                        tick_next_s = tick_r + 8'd1;
                    end
                end
                ST_DATA: begin
                    if (tick_r == OSR_M1) begin
                        tick_next_s = 8'd0;
                        if (bit_r != last_bit_s) bit_next_s   = bit_r + 3'd1;
                        else if (lcr_r[3])       state_next_s = ST_PARITY;
                        else                     state_next_s = ST_STOP;
                    end else begin
                        tick_next_s = tick_r + 8'd1;
                    end
                end
                ST_PARITY: begin
                    if (tick_r == OSR_M1) begin
                        state_next_s = ST_STOP;
                        tick_next_s  = 8'd0;
                    end else begin
                        tick_next_s = tick_r + 8'd1;
                    end
                end
                ST_STOP: begin
                    if (tick_r == stop_last_s) begin
                        tick_next_s = 8'd0;
                        if (!empty_r && cts_ok_s) state_next_s = ST_POP;
                        else                      state_next_s = ST_IDLE;
                    end else begin
                        tick_next_s = tick_r + 8'd1;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    tick_next_s  = 8'd0;
                    bit_next_s   = 3'd0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Line level for the state being entered, so the pad changes on the same edge as the FSM.
    always_comb begin
        case (state_next_s)
            ST_START:  line_next_s = 1'b0;
            ST_DATA:   line_next_s = data_r[bit_next_s];
            ST_PARITY: line_next_s = parity_bit(parity_r, lcr_r[4], lcr_r[5]);
            default:   line_next_s = 1'b1;
        endcase
    end

    // Datapath: counters, registered line, and per-frame character/settings latched on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_r   <= 8'd0;
            bit_r    <= 3'd0;
            line_r   <= 1'b1;
            data_r   <= 8'd0;
            lcr_r    <= 6'd0;
            parity_r <= 1'b0;
        end else begin
            tick_r <= tick_next_s;
            bit_r  <= bit_next_s;
            line_r <= line_next_s;
            if (pop_s) begin
                data_r   <= head_masked_s;
                lcr_r    <= lcr[5:0];
                parity_r <= ^head_masked_s;
            end
        end
    end

    assign stx_pad_o  = line_r & ~lcr[6];
    assign tstate     = state_r;
    assign tf_count   = count_r;
    assign tf_full    = full_r;
    assign tf_empty   = empty_r;
    assign tf_overrun = overrun_r;
    assign tx_idle    = tx_idle_r;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: table-driven frame vectors, FIFO corner sequences,
// and randomised multi-frame traffic checked against a per-tick line-level model.
module tb_uart_tx_engine;
    localparam int DEPTH = 4;
    localparam int OSR   = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, enable, wr_en, tx_reset, ovr_clr;
    logic [7:0]    lcr, wr_data;
    logic          stx_pad_o, tf_full, tf_empty, tf_overrun, tx_idle;
    logic [2:0]    tstate;
    logic [CW-1:0] tf_count;
`ifdef UART_TX_CTS_EN
    logic          cts_n;
`endif

    int checks = 0;
    int errors = 0;
    bit         line_q[$];
    logic [2:0] st_q[$];
    bit         exp_q[$];

    typedef struct {
        logic [7:0] lcr;
        logic [7:0] data;
        int         frame_len;
        int         stop_len;
        bit         par;
    } vec_t;
    vec_t vecs[10];

    uart_tx_engine #(.FIFO_DEPTH(DEPTH), .OSR(OSR)) dut (
        .clk(clk), .rst(rst), .enable(enable), .lcr(lcr), .wr_en(wr_en), .wr_data(wr_data),
        .tx_reset(tx_reset), .ovr_clr(ovr_clr),
`ifdef UART_TX_CTS_EN
        .cts_n(cts_n),
`endif
        .stx_pad_o(stx_pad_o), .tstate(tstate), .tf_count(tf_count), .tf_full(tf_full),
        .tf_empty(tf_empty), .tf_overrun(tf_overrun), .tx_idle(tx_idle)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic clear_cap();
        line_q.delete(); st_q.delete(); exp_q.delete();
    endtask

    // One baud tick; the line and state are recorded after the edge that consumed it.
    task automatic tick();
        @(negedge clk); enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        line_q.push_back(stx_pad_o);
        st_q.push_back(tstate);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [7:0] d);
        @(negedge clk); wr_en = 1'b1; wr_data = d;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic tick_push(input logic [7:0] d);
        @(negedge clk); enable = 1'b1; wr_en = 1'b1; wr_data = d;
        @(negedge clk); enable = 1'b0; wr_en = 1'b0;
        line_q.push_back(stx_pad_o);
        st_q.push_back(tstate);
    endtask

    // Expected line level after each tick for one frame, starting with its POP tick.
    function automatic void model_frame(input logic [7:0] l, input logic [7:0] d);
        int n = 5 + int'(l[1:0]);
        int ones = 0;
        int stop;
        bit p;
        exp_q.push_back(1'b1);
        repeat (OSR) exp_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            repeat (OSR) exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (l[3]) begin
            if (l[5])      p = ~l[4];
            else if (l[4]) p = (ones % 2 == 1);
            else           p = (ones % 2 == 0);
            repeat (OSR) exp_q.push_back(p);
        end
        if (!l[2])              stop = OSR;
        else if (l[1:0] == 2'b00) stop = (3 * OSR) / 2;
        else                    stop = 2 * OSR;
        repeat (stop) exp_q.push_back(1'b1);
    endfunction

    task automatic compare_stream(input string name);
        int bad = -1;
        while (exp_q.size() < line_q.size()) exp_q.push_back(1'b1);
        checks++;
        if (exp_q.size() != line_q.size()) bad = line_q.size();
        else for (int i = 0; i < line_q.size(); i++) if (bad < 0 && line_q[i] != exp_q[i]) bad = i;
        if (bad >= 0) begin
            errors++;
            if (bad < line_q.size())
                $display("FAIL %s: line after tick %0d is %0d, required %0d", name, bad, line_q[bad], exp_q[bad]);
            else
                $display("FAIL %s: captured %0d ticks, model needs %0d", name, line_q.size(), exp_q.size());
        end
    endtask

    initial begin
        int n, flen, slen, dec, nb, base;
        logic [7:0] d;
        rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
        tx_reset = 1'b0; ovr_clr = 1'b0; lcr = 8'h03;
`ifdef UART_TX_CTS_EN
        cts_n = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_line", stx_pad_o, 1'b1);
        check("reset_tstate", tstate, 3'd0);
        check("reset_count", tf_count, 0);
        check("reset_empty", tf_empty, 1'b1);
        check("reset_full", tf_full, 1'b0);
        check("reset_overrun", tf_overrun, 1'b0);
        check("reset_idle", tx_idle, 1'b1);

        vecs[0] = '{8'h03, 8'hA5, 160, 16, 1'b0};
        vecs[1] = '{8'h1B, 8'h07, 176, 16, 1'b1};
        vecs[2] = '{8'h0B, 8'h07, 176, 16, 1'b0};
        vecs[3] = '{8'h2B, 8'h07, 176, 16, 1'b1};
        vecs[4] = '{8'h3B, 8'h07, 176, 16, 1'b0};
        vecs[5] = '{8'h04, 8'h15, 120, 24, 1'b0};
        vecs[6] = '{8'h07, 8'hC3, 176, 32, 1'b0};
        vecs[7] = '{8'h08, 8'hE3, 128, 16, 1'b1};
        vecs[8] = '{8'h0E, 8'h80, 176, 32, 1'b1};
        vecs[9] = '{8'h19, 8'h3F, 144, 16, 1'b0};
        for (int v = 0; v < 10; v++) begin
            clear_cap();
            lcr = vecs[v].lcr;
            push(vecs[v].data);
            ticks(vecs[v].frame_len + 3);
            n = 5 + int'(vecs[v].lcr[1:0]);
            flen = 0; slen = 0; dec = 0;
            foreach (st_q[i]) begin
                if (st_q[i] >= 3'd1 && st_q[i] <= 3'd4) flen++;
                if (st_q[i] == 3'd4) slen++;
            end
            for (int i = 0; i < n; i++) dec[i] = line_q[1 + OSR + i * OSR + OSR / 2];
            check($sformatf("vec%0d_frame_len", v), flen, vecs[v].frame_len);
            check($sformatf("vec%0d_stop_len", v), slen, vecs[v].stop_len);
            check($sformatf("vec%0d_data", v), dec, int'(vecs[v].data) & ((1 << n) - 1));
            if (vecs[v].lcr[3])
                check($sformatf("vec%0d_parity", v), line_q[1 + OSR * (1 + n) + OSR / 2], vecs[v].par);
            model_frame(vecs[v].lcr, vecs[v].data);
            compare_stream($sformatf("vec%0d_stream", v));
            check($sformatf("vec%0d_idle", v), tx_idle, 1'b1);
        end

        // Overrun and flush while a frame is in flight.
        clear_cap(); lcr = 8'h03;
        push(8'h11); tick(); tick();
        check("ovr_popped_count", tf_count, 0);
        for (int i = 0; i < 6; i++) push(8'(8'h22 + i));
        check("ovr_count", tf_count, 4);
        check("ovr_full", tf_full, 1'b1);
        check("ovr_flag", tf_overrun, 1'b1);
        @(negedge clk); wr_en = 1'b1; ovr_clr = 1'b1;
        @(negedge clk); wr_en = 1'b0; ovr_clr = 1'b0;
        check("ovr_clr_loses", tf_overrun, 1'b1);
        @(negedge clk); ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        check("ovr_clr_alone", tf_overrun, 1'b0);
        push(8'h99);
        check("ovr_set_again", tf_overrun, 1'b1);
        @(negedge clk); tx_reset = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk); tx_reset = 1'b0; wr_en = 1'b0;
        check("flush_count", tf_count, 0);
        check("flush_overrun", tf_overrun, 1'b0);
        check("flush_empty", tf_empty, 1'b1);
        ticks(161 + 3 - 2);
        model_frame(8'h03, 8'h11);
        compare_stream("flush_frame_completes");
        check("flush_idle", tx_idle, 1'b1);

        // Full FIFO: push and pop on the same clock keeps the count; five frames back-to-back.
        clear_cap();
        for (int i = 0; i < 4; i++) push(8'(8'h31 * (i + 1)));
        tick();
        tick_push(8'h5A);
        check("pushpop_count", tf_count, 4);
        check("pushpop_full", tf_full, 1'b1);
        check("pushpop_overrun", tf_overrun, 1'b0);
        ticks(5 * 161 + 3 - 2);
        for (int i = 0; i < 4; i++) model_frame(8'h03, 8'(8'h31 * (i + 1)));
        model_frame(8'h03, 8'h5A);
        compare_stream("back_to_back_stream");

        // Settings written mid-frame apply to the next frame only.
        clear_cap();
        push(8'h6C); push(8'h07);
        ticks(50);
        lcr = 8'h1B;
        ticks(161 + 177 + 3 - 50);
        model_frame(8'h03, 8'h6C); model_frame(8'h1B, 8'h07);
        compare_stream("lcr_midframe_stream");

        // Randomised traffic.
        for (int r = 0; r < 12; r++) begin
            clear_cap();
            lcr = 8'($urandom) & 8'hBF;
            nb = int'($urandom_range(1, 3));
            for (int i = 0; i < nb; i++) begin
                d = 8'($urandom);
                push(d);
                model_frame(lcr, d);
            end
            ticks(exp_q.size() + 3);
            compare_stream($sformatf("rand%0d_lcr%02h_stream", r, lcr));
            check($sformatf("rand%0d_idle", r), tx_idle, 1'b1);
        end

        // Break forces the line low combinationally.
        lcr = 8'h43; #1;
        check("break_low", stx_pad_o, 1'b0);
        lcr = 8'h03; #1;
        check("break_release", stx_pad_o, 1'b1);

`ifdef UART_TX_CTS_EN
        clear_cap(); cts_n = 1'b1;
        repeat (3) @(negedge clk);
        push(8'h55); push(8'h0F);
        ticks(20);
        base = 0; foreach (line_q[i]) if (!line_q[i]) base++;
        check("cts_hold_line", base, 0);
        check("cts_hold_state", tstate, 3'd0);
        clear_cap(); cts_n = 1'b0;
        ticks(4);
        check("cts_start_within_4", line_q[3], 1'b0);
        ticks(30); cts_n = 1'b1;
        ticks(200);
        check("cts_frame_done", tstate, 3'd0);
        check("cts_next_held", tf_count, 1);
        cts_n = 1'b0;
        ticks(200);
        check("cts_drained", tx_idle, 1'b1);
`endif

        // Reset in the middle of a frame returns the line high at once.
        clear_cap();
        push(8'h00); push(8'hFF);
        ticks(20);
        check("pre_reset_line", stx_pad_o, 1'b0);
        check("pre_reset_count", tf_count, 1);
        @(negedge clk); rst = 1'b1; #1;
        check("midreset_line", stx_pad_o, 1'b1);
        check("midreset_count", tf_count, 0);
        check("midreset_state", tstate, 3'd0);
        @(negedge clk); rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
